// File: rtl/cms_pair_framer.sv
// Pairs the y and y_hat sample streams through two small FIFOs and frames the
// pairs into blocks of 2^log2_samples, with a fixed idle gap after each frame.

module cms_pair_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_head,
  output logic              o_full,
  output logic              o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_q;
  logic [AW:0]       rd_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (i_push) wr_q <= wr_q + PTR_ONE;
      if (i_pop)  rd_q <= rd_q + PTR_ONE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) mem_q[wr_q[AW-1:0]] <= i_data;
  end

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign o_empty = (wr_q == rd_q);
  assign o_full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign o_head  = mem_q[rd_q[AW-1:0]];
endmodule

// state  | meaning
// IDLE   | waiting for the first pair of a frame; latches the frame length
// ACTIVE | mid-frame, popping pairs until the last one
// GAP    | forced idle after a frame so the accumulator can publish
module cms_pair_framer #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int FRAME_GAP  = 2
) (
  input  logic              i_clk,
  input  logic              i_arst_n,
  input  logic              i_en,
  input  logic [2:0]        i_log2_samples,
  input  logic              i_y_valid,
  output logic              o_y_ready,
  input  logic [DATA_W-1:0] i_y,
  input  logic              i_yh_valid,
  output logic              o_yh_ready,
  input  logic [DATA_W-1:0] i_y_hat,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_y,
  output logic [DATA_W-1:0] o_y_hat,
  output logic              o_last,
  output logic [15:0]       o_frames
);
  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_GAP} state_t;

  localparam bit         GAP_EN   = (FRAME_GAP != 0);
  localparam logic [3:0] GAP_INIT = 4'((FRAME_GAP > 0) ? FRAME_GAP - 1 : 0);

  state_t            state_q;
  logic [7:0]        cnt_q;
  logic [7:0]        len_q;
  logic [3:0]        gcnt_q;
  logic              rdy_q;
  logic              valid_q;
  logic              last_q;
  logic [DATA_W-1:0] y_q;
  logic [DATA_W-1:0] yh_q;
  logic [15:0]       frames_q;

  logic              y_full, y_empty, yh_full, yh_empty;
  logic [DATA_W-1:0] y_head, yh_head;
  logic              push_y, push_yh, pop;
  logic [7:0]        n_sel;

  // rdy_q holds both readies low for the reset cycle itself.
  assign o_y_ready  = rdy_q & ~y_full;
  assign o_yh_ready = rdy_q & ~yh_full;
  assign push_y     = i_y_valid & o_y_ready;
  assign push_yh    = i_yh_valid & o_yh_ready;
  assign pop        = i_en & ~y_empty & ~yh_empty &
                      ((state_q == S_IDLE) | (state_q == S_ACTIVE));
  assign n_sel      = 8'd1 << i_log2_samples;

  cms_pair_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo_y (
    .i_clk   (i_clk),
    .i_rst_n (i_arst_n),
    .i_push  (push_y),
    .i_pop   (pop),
    .i_data  (i_y),
    .o_head  (y_head),
    .o_full  (y_full),
    .o_empty (y_empty)
  );

  cms_pair_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo_yh (
    .i_clk   (i_clk),
    .i_rst_n (i_arst_n),
    .i_push  (push_yh),
    .i_pop   (pop),
    .i_data  (i_y_hat),
    .o_head  (yh_head),
    .o_full  (yh_full),
    .o_empty (yh_empty)
  );

  always_ff @(posedge i_clk) begin
    if (!i_arst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      len_q    <= '0;
      gcnt_q   <= '0;
      rdy_q    <= 1'b0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      y_q      <= '0;
      yh_q     <= '0;
      frames_q <= '0;
    end else begin
      rdy_q   <= 1'b1;
      valid_q <= pop;
      y_q     <= pop ? y_head  : '0;
      yh_q    <= pop ? yh_head : '0;
      last_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            len_q <= n_sel;
            cnt_q <= 8'd1;
            if (n_sel == 8'd1) begin
              last_q   <= 1'b1;
              frames_q <= frames_q + 16'd1;
              gcnt_q   <= GAP_INIT;
              state_q  <= GAP_EN ? S_GAP : S_IDLE;
            end else begin
              state_q <= S_ACTIVE;
            end
          end
        end
        S_ACTIVE: begin
          if (pop) begin
            if (cnt_q == len_q - 8'd1) begin
              last_q   <= 1'b1;
              frames_q <= frames_q + 16'd1;
              cnt_q    <= '0;
              gcnt_q   <= GAP_INIT;
              state_q  <= GAP_EN ? S_GAP : S_IDLE;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
        end
        S_GAP: begin
          // Terminal count reached: the gap has lasted FRAME_GAP cycles.
          if (gcnt_q == 4'd0) state_q <= S_IDLE;
          else                gcnt_q  <= gcnt_q - 4'd1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_valid  = valid_q;
  assign o_last   = last_q;
  assign o_y      = y_q;
  assign o_y_hat  = yh_q;
  assign o_frames = frames_q;
endmodule

// File: tb/tb_cms_pair_framer.sv
// Randomized bench for cms_pair_framer: a queue-based frame model predicts every
// output cycle, and each scenario task also checks its own fixed expectations.

module tb_cms_pair_framer;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int GAP   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, en;
  logic [2:0]    log2;
  logic          y_valid, yh_valid, y_ready, yh_ready, valid, last;
  logic [DW-1:0] y, yh, oy, oyh;
  logic [15:0]   frames;

  logic          y2_valid, yh2_valid, y2_ready, yh2_ready, valid2, last2;
  logic [DW-1:0] y2, yh2, oy2, oyh2;
  logic [15:0]   frames2;

  cms_pair_framer #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .FRAME_GAP(GAP)) dut (
    .i_clk(clk), .i_arst_n(rst_n), .i_en(en), .i_log2_samples(log2),
    .i_y_valid(y_valid), .o_y_ready(y_ready), .i_y(y),
    .i_yh_valid(yh_valid), .o_yh_ready(yh_ready), .i_y_hat(yh),
    .o_valid(valid), .o_y(oy), .o_y_hat(oyh), .o_last(last), .o_frames(frames)
  );

  cms_pair_framer #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .FRAME_GAP(0)) dut_g0 (
    .i_clk(clk), .i_arst_n(rst_n), .i_en(en), .i_log2_samples(log2),
    .i_y_valid(y2_valid), .o_y_ready(y2_ready), .i_y(y2),
    .i_yh_valid(yh2_valid), .o_yh_ready(yh2_ready), .i_y_hat(yh2),
    .o_valid(valid2), .o_y(oy2), .o_y_hat(oyh2), .o_last(last2), .o_frames(frames2)
  );

  typedef struct packed {
    logic          valid;
    logic          last;
    logic          yr;
    logic          yhr;
    logic [15:0]   frames;
    logic [DW-1:0] y;
    logic [DW-1:0] yh;
  } snap_t;

  snap_t obs_q[$], exp_q[$];
  int    total = 0, bad = 0;
  bit    rec = 0;
  int    thr = 100;

  // Reference model: two sample queues plus a frame position and gap timer.
  logic [DW-1:0] mq_y[$], mq_yh[$];
  int            m_pos, m_len, m_gap, m_frames;
  bit            m_rdy, m_valid, m_last, m_py, m_pyh, m_pop, hs_y, hs_yh;
  logic [DW-1:0] m_y, m_yh;

  always @(posedge clk) begin
    hs_y  = y_valid && y_ready;
    hs_yh = yh_valid && yh_ready;
    if (!rst_n) begin
      mq_y.delete(); mq_yh.delete();
      m_pos = 0; m_len = 1; m_gap = 0; m_frames = 0; m_rdy = 0;
      m_valid = 0; m_last = 0; m_y = '0; m_yh = '0;
    end else begin
      m_py  = y_valid && m_rdy && (mq_y.size() < DEPTH);
      m_pyh = yh_valid && m_rdy && (mq_yh.size() < DEPTH);
      m_pop = en && (mq_y.size() > 0) && (mq_yh.size() > 0) && (m_gap == 0);
      m_valid = 0; m_last = 0; m_y = '0; m_yh = '0;
      if (m_gap > 0) m_gap--;
      if (m_pop) begin
        if (m_pos == 0) m_len = 1 << log2;
        m_valid = 1;
        m_y  = mq_y.pop_front();
        m_yh = mq_yh.pop_front();
        m_pos++;
        if (m_pos == m_len) begin
          m_last = 1; m_pos = 0; m_gap = GAP;
          m_frames = (m_frames + 1) % 65536;
        end
      end
      if (m_py)  mq_y.push_back(y);
      if (m_pyh) mq_yh.push_back(yh);
      m_rdy = 1;
    end
  end

  // Source queues presented on the input handshakes with optional throttling.
  logic [DW-1:0] src_y[$], src_yh[$];

  always @(negedge clk) begin
    if (hs_y && src_y.size() > 0) void'(src_y.pop_front());
    if (hs_yh && src_yh.size() > 0) void'(src_yh.pop_front());
    y_valid  = (src_y.size() > 0) && ($urandom_range(99) < thr);
    yh_valid = (src_yh.size() > 0) && ($urandom_range(99) < thr);
    y  = (src_y.size() > 0) ? src_y[0] : DW'($urandom);
    yh = (src_yh.size() > 0) ? src_yh[0] : DW'($urandom);
  end

  always @(negedge clk) begin
    snap_t so, se;
    if (rec) begin
      so = {valid, last, y_ready, yh_ready, frames, oy, oyh};
      se = {m_valid, m_last, m_rdy && (mq_y.size() < DEPTH),
            m_rdy && (mq_yh.size() < DEPTH), 16'(m_frames), m_y, m_yh};
      obs_q.push_back(so);
      exp_q.push_back(se);
    end
  end

  function automatic bit drained();
    return src_y.size() == 0 && src_yh.size() == 0 && mq_y.size() == 0 && mq_yh.size() == 0;
  endfunction

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 0; en = 1; thr = 100;
    src_y.delete(); src_yh.delete();
    repeat (n) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic start_rec();
    obs_q.delete(); exp_q.delete(); rec = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({valid, last, frames, oy, oyh} !== '0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0", {valid, last, frames, oy, oyh});
    end
    total++;
    if ({y_ready, yh_ready} !== 2'b00) begin
      bad++; $display("FAIL reset_ready got=%b want=00", {y_ready, yh_ready});
    end
    rst_n = 1;
    @(negedge clk); #1;
    total++;
    if ({y_ready, yh_ready} !== 2'b11) begin
      bad++; $display("FAIL release_ready got=%b want=11", {y_ready, yh_ready});
    end
  endtask

  // Two back-to-back 8-pair frames: contiguous pairs, exact gap, ordered data.
  task automatic test_basic();
    int vi[$];
    do_reset(2); log2 = 3; start_rec();
    @(posedge clk); #1;
    for (int k = 0; k < 16; k++) begin
      src_y.push_back(DW'(k)); src_yh.push_back(DW'(k + 32'h10000));
    end
    for (int c = 0; c < 100 && !drained(); c++) @(negedge clk);
    total++;
    if (!drained()) begin bad++; $display("FAIL basic_timeout got=busy want=drained"); end
    repeat (5) @(negedge clk);
    rec = 0;
    for (int i = 0; i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL basic_stream cyc=%0d got=%h want=%h", i, obs_q[i], exp_q[i]);
      end
      if (obs_q[i].valid) vi.push_back(i);
    end
    total++;
    if (vi.size() != 16) begin
      bad++; $display("FAIL basic_count got=%0d want=16", vi.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        total++;
        if (obs_q[vi[i]].y !== DW'(i) || obs_q[vi[i]].yh !== DW'(i + 32'h10000) ||
            obs_q[vi[i]].last !== ((i % 8) == 7)) begin
          bad++; $display("FAIL basic_pair%0d got=%h/%h last=%b", i, obs_q[vi[i]].y,
                          obs_q[vi[i]].yh, obs_q[vi[i]].last);
        end
        if (i != 0) begin
          total++;
          if (vi[i] - vi[i-1] != ((i == 8) ? GAP + 1 : 1)) begin
            bad++; $display("FAIL basic_spacing%0d got=%0d want=%0d", i, vi[i] - vi[i-1],
                            (i == 8) ? GAP + 1 : 1);
          end
        end
      end
      total++;
      if (obs_q[vi[7]].frames !== 16'd1) begin
        bad++; $display("FAIL basic_frames got=%0d want=1", obs_q[vi[7]].frames);
      end
    end
  endtask

  task automatic test_skew();
    int nv = 0;
    do_reset(2); log2 = 2; start_rec();
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) src_y.push_back(DW'($urandom));
    repeat (8) @(negedge clk);
    #1;
    total++;
    if ({y_ready, yh_ready, valid} !== 3'b010) begin
      bad++; $display("FAIL skew_full got=%b want=010", {y_ready, yh_ready, valid});
    end
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) src_yh.push_back(DW'($urandom));
    @(negedge clk);
    @(negedge clk); #1;
    total++;
    if (valid !== 1'b0) begin bad++; $display("FAIL skew_early got=%b want=0", valid); end
    @(negedge clk); #1;
    total++;
    if (valid !== 1'b1) begin bad++; $display("FAIL skew_latency got=%b want=1", valid); end
    for (int c = 0; c < 40 && !drained(); c++) @(negedge clk);
    total++;
    if (!drained()) begin bad++; $display("FAIL skew_timeout got=busy want=drained"); end
    repeat (4) @(negedge clk);
    rec = 0;
    for (int i = 0; i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL skew_stream cyc=%0d got=%h want=%h", i, obs_q[i], exp_q[i]);
      end
      if (obs_q[i].valid) nv++;
    end
    total++;
    if (nv != 4 || frames !== 16'd1) begin
      bad++; $display("FAIL skew_pairs got=%0d/%0d want=4/1", nv, frames);
    end
  endtask

  task automatic test_stall();
    int vi[$];
    do_reset(2); log2 = 2; en = 0; start_rec();
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      src_y.push_back(DW'($urandom)); src_yh.push_back(DW'($urandom));
    end
    repeat (7) @(negedge clk);
    en = 1;
    repeat (2) @(negedge clk);
    en = 0;
    repeat (5) @(negedge clk);
    en = 1;
    repeat (6) @(negedge clk);
    rec = 0;
    for (int i = 0; i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL stall_stream cyc=%0d got=%h want=%h", i, obs_q[i], exp_q[i]);
      end
      if (obs_q[i].valid) vi.push_back(i);
    end
    total++;
    if (vi.size() != 4) begin
      bad++; $display("FAIL stall_count got=%0d want=4", vi.size());
    end else begin
      total++;
      if (vi[1] - vi[0] != 1 || vi[2] - vi[1] != 6 || vi[3] - vi[2] != 1) begin
        bad++; $display("FAIL stall_spacing got=%0d,%0d,%0d want=1,6,1",
                        vi[1] - vi[0], vi[2] - vi[1], vi[3] - vi[2]);
      end
      total++;
      if (obs_q[vi[3]].last !== 1'b1 || obs_q[vi[3]].frames !== 16'd1 || obs_q[vi[2]].last !== 1'b0) begin
        bad++; $display("FAIL stall_last got=%b/%0d want=1/1", obs_q[vi[3]].last, obs_q[vi[3]].frames);
      end
    end
  endtask

  task automatic test_len_change();
    int   nv = 0;
    logic lp[$];
    do_reset(2); log2 = 2; start_rec();
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) begin
      src_y.push_back(DW'($urandom)); src_yh.push_back(DW'($urandom));
    end
    for (int c = 0; c < 20 && valid !== 1'b1; c++) @(negedge clk);
    log2 = 0;
    for (int c = 0; c < 100 && !drained(); c++) @(negedge clk);
    total++;
    if (!drained()) begin bad++; $display("FAIL len_timeout got=busy want=drained"); end
    repeat (5) @(negedge clk);
    rec = 0;
    for (int i = 0; i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL len_stream cyc=%0d got=%h want=%h", i, obs_q[i], exp_q[i]);
      end
      if (obs_q[i].valid) lp.push_back(obs_q[i].last);
    end
    total++;
    if (lp.size() != 8 || {lp[0], lp[1], lp[2], lp[3], lp[4], lp[5], lp[6], lp[7]} !== 8'b00011111) begin
      bad++; $display("FAIL len_lastpattern got=%0d pairs want=8 with 00011111", lp.size());
    end
    total++;
    if (frames !== 16'd5) begin bad++; $display("FAIL len_frames got=%0d want=5", frames); end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    int vi[$];
    do_reset(2); log2 = 3; start_rec();
    @(posedge clk); #1;
    for (int k = 0; k < 16; k++) begin
      src_y.push_back(DW'(32'h500 + k)); src_yh.push_back(DW'(32'h900 + k));
    end
    for (int c = 0; c < 60 && frames !== 16'd1; c++) @(negedge clk);
    for (int c = 0; c < 60 && seen < 3; c++) begin
      @(negedge clk); #1;
      if (valid) seen++;
    end
    rst_n = 0;
    @(negedge clk); #1;
    total++;
    if ({valid, last, y_ready, yh_ready, frames, oy, oyh} !== '0) begin
      bad++; $display("FAIL midreset_outputs got=%h want=0", {valid, last, y_ready, yh_ready, frames, oy, oyh});
    end
    src_y.delete(); src_yh.delete();
    rst_n = 1;
    obs_q.delete(); exp_q.delete();
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) begin
      src_y.push_back(DW'(32'h100 + k)); src_yh.push_back(DW'(32'h200 + k));
    end
    for (int c = 0; c < 60 && !drained(); c++) @(negedge clk);
    total++;
    if (!drained()) begin bad++; $display("FAIL midreset_timeout got=busy want=drained"); end
    repeat (4) @(negedge clk);
    rec = 0;
    for (int i = 0; i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL midreset_stream cyc=%0d got=%h want=%h", i, obs_q[i], exp_q[i]);
      end
      if (obs_q[i].valid) vi.push_back(i);
    end
    total++;
    if (vi.size() != 8) begin
      bad++; $display("FAIL midreset_count got=%0d want=8", vi.size());
    end else begin
      total++;
      if (obs_q[vi[0]].y !== DW'(32'h100) || obs_q[vi[7]].yh !== DW'(32'h207) ||
          obs_q[vi[7]].last !== 1'b1 || frames !== 16'd1) begin
        bad++; $display("FAIL midreset_frame got=%h/%h/%b/%0d want=100/207/1/1",
                        obs_q[vi[0]].y, obs_q[vi[7]].yh, obs_q[vi[7]].last, frames);
      end
    end
  endtask

  task automatic test_random();
    int ny = 0, nh = 0, nv = 0;
    do_reset(2); log2 = 1; thr = 60; start_rec();
    for (int c = 0; c < 500; c++) begin
      @(posedge clk); #1;
      if (ny < 60 && $urandom_range(2) == 0) begin src_y.push_back(DW'($urandom)); ny++; end
      if (nh < 60 && $urandom_range(2) == 0) begin src_yh.push_back(DW'($urandom)); nh++; end
      en = ($urandom_range(9) < 8);
      if ($urandom_range(15) == 0) log2 = 3'($urandom_range(3));
    end
    en = 1; thr = 100;
    for (int c = 0; c < 200 && !drained(); c++) @(negedge clk);
    total++;
    if (!drained()) begin bad++; $display("FAIL random_timeout got=busy want=drained"); end
    repeat (4) @(negedge clk);
    rec = 0;
    for (int i = 0; i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL random_stream cyc=%0d got=%h want=%h", i, obs_q[i], exp_q[i]);
      end
      if (obs_q[i].valid) nv++;
    end
    total++;
    if (nv != 60) begin bad++; $display("FAIL random_pairs got=%0d want=60", nv); end
  endtask

  task automatic test_gap0();
    int   k = 0, cyc = 0;
    int   pos[$];
    logic lst[$];
    logic [DW-1:0] dy[$], dh[$];
    do_reset(2); log2 = 1; en = 1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk); #1;
      if (valid2) begin pos.push_back(c); lst.push_back(last2); dy.push_back(oy2); dh.push_back(oyh2); end
      y2_valid = (k < 12); yh2_valid = (k < 12);
      y2 = DW'(k); yh2 = DW'(k + 32'h10000);
      @(posedge clk);
      if (y2_valid && y2_ready && yh2_ready) k++;
    end
    y2_valid = 0; yh2_valid = 0;
    total++;
    if (pos.size() != 12) begin
      bad++; $display("FAIL gap0_count got=%0d want=12", pos.size());
    end else begin
      total++;
      if (pos[11] - pos[0] != 11) begin
        bad++; $display("FAIL gap0_continuous got=%0d want=11", pos[11] - pos[0]);
      end
      for (int i = 0; i < 12; i++) begin
        total++;
        if (lst[i] !== ((i % 2) == 1) || dy[i] !== DW'(i) || dh[i] !== DW'(i + 32'h10000)) begin
          bad++; $display("FAIL gap0_pair%0d got=%h/%h last=%b", i, dy[i], dh[i], lst[i]);
        end
      end
    end
    total++;
    if (frames2 !== 16'd6) begin bad++; $display("FAIL gap0_frames got=%0d want=6", frames2); end
  endtask

  initial begin
    rst_n = 0; en = 1; log2 = 0;
    y2_valid = 0; yh2_valid = 0; y2 = '0; yh2 = '0;
    test_reset();
    test_basic();
    test_skew();
    test_stall();
    test_len_change();
    test_reset_mid();
    test_random();
    test_gap0();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1);
  end
endmodule

// File: doc/cms_pair_framer.md
Name: cms_pair_framer

Overview:
Upstream feeder for complex_mean_square.
- Accepts the reference stream (y) and the estimate stream (y_hat) on two independent valid/ready interfaces.
- Buffers each stream in a small FIFO, aligns the two streams into sample pairs, and frames the pairs into blocks of 2^log2_samples.
- Output drives the mean-square unit's i_valid/i_y/i_y_hat directly. A fixed idle gap follows each frame so the accumulator can publish its result.

Parameters:
DATA_W, 32, width of each packed complex sample (real [DATA_W-1:DATA_W/2], imag [DATA_W/2-1:0]); passed through untouched
FIFO_DEPTH, 4, entries per input FIFO; power of two, at least 2
FRAME_GAP, 2, cycles with o_valid=0 forced after each frame's last pair; range 0..15

Ports:
i_clk  in  1  clock, all logic on rising edge
i_arst_n  in  1  reset, synchronous, active-low
i_en  in  1  pairing enable; low stalls pops only
i_log2_samples  in  3  frame length exponent, sampled at frame start
i_y_valid  in  1  y sample offered
o_y_ready  out  1  y FIFO can accept
i_y  in  DATA_W  y sample
i_yh_valid  in  1  y_hat sample offered
o_yh_ready  out  1  y_hat FIFO can accept
i_y_hat  in  DATA_W  y_hat sample
o_valid  out  1  aligned pair valid (to CMS i_valid)
o_y  out  DATA_W  paired y
o_y_hat  out  DATA_W  paired y_hat
o_last  out  1  pair is final sample of frame
o_frames  out  16  completed-frame counter, wraps 0xFFFF->0

Behaviour:
- Reset (i_arst_n=0 at rising edge):
  - Both FIFOs emptied; state=IDLE; pair counter, gap counter and o_frames = 0.
  - o_valid, o_last, o_y, o_y_hat = 0.
  - o_y_ready and o_yh_ready = 0 during reset, and 1 from the first cycle after release.
  - Reset mid-frame discards the partial frame with no o_last.
- Input side:
  - o_y_ready = ~y_full; a push occurs when i_y_valid & o_y_ready at the edge. The y_hat side works the same way.
  - Ready is not pop-aware, so a full FIFO never accepts.
  - Push and pop of the same FIFO in one cycle leaves its occupancy unchanged.
  - Pushes are independent of i_en and state.
- Pop condition: pop = i_en & y_nonempty & yh_nonempty & (state==IDLE | state==ACTIVE). Both FIFOs always pop together.
- Output timing:
  - Outputs are registered. A pop at edge k gives o_valid=1 with FIFO head data during the cycle after edge k.
  - Otherwise o_valid=0 and o_y = o_y_hat = o_last = 0.
- Latency: both samples pushed at edge k into empty FIFOs -> o_valid high after edge k+1, i.e. 2 cycles.
- FSM:
  - IDLE: on pop, latch N = 1<<i_log2_samples and set cnt=1. If N==1, o_last=1 and go to GAP (or to IDLE if FRAME_GAP=0); otherwise go to ACTIVE.
  - ACTIVE: each pop increments cnt. The pop with cnt==N-1 (before increment) asserts o_last and goes to GAP (or IDLE if FRAME_GAP=0).
  - GAP: no pops; gcnt counts FRAME_GAP cycles, then go to IDLE.
  - o_frames increments on the same edge that registers o_last=1.
- i_en low:
  - Pops stall and cnt holds; the frame resumes when i_en returns.
  - The GAP countdown continues regardless of i_en.
- i_log2_samples changes mid-frame are ignored until the next IDLE->ACTIVE transition.
- Skew: one stream may run ahead by up to FIFO_DEPTH samples. After that, its ready drops until the other stream catches up. No data is ever dropped or reordered.
- Back-to-back: with both FIFOs fed every cycle and i_en=1, o_valid is continuous within a frame. Exactly FRAME_GAP zero cycles separate frames.

Test Plan:
- Reset then feed 8 pairs: i_log2_samples=3, y=k, y_hat=k+0x10000 on both streams every cycle (k=0..7) -> 8 consecutive o_valid pairs in order, o_last on pair 7, o_frames=1, then 2 cycles of o_valid=0.
- Skewed streams: push 4 y samples while y_hat is idle -> o_y_ready drops after the 4th, no o_valid. Then push 4 y_hat -> 4 aligned pairs appear, the first 2 cycles after the first y_hat handshake.
- Enable stall: i_log2_samples=2, pairs available, i_en dropped after pair 1 for 5 cycles -> o_valid=0 for those cycles, remaining pairs 2..3 follow with o_last on the 4th, o_frames=1.
- Length change mid-frame: start frame with log2=2, switch to 0 after pair 0 -> first frame still 4 pairs. After GAP, each single pair carries o_last, and o_frames increments per pair.
- Synchronous reset mid-frame: assert i_arst_n=0 for 1 cycle after pair 2 of 8 -> next cycle all outputs 0, FIFOs empty, o_frames=0. A new 8-pair frame completes normally.
- FRAME_GAP=0 build, log2=1, continuous input -> o_valid stays high continuously and o_last toggles every second pair.
